io_uart_tx: RTL and testbench

Memory-mapped UART transmitter that is the responder on the system bus IO port (`io_addr`, `io_read_data`, `io_write_data`, `io_write_en`). CPU stores push bytes into a TX FIFO, and a baud-rate FSM serialises them onto `uart_tx` as 8N1 frames, or 8E1 when parity is compiled in. Status and divisor registers are readable through the same port. Reads are combinational and have no side effects, because the bus carries no read strobe.

---
 rtl/io_uart_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/io_uart_tx.sv | 193 +++++++++++++++++++
 tb/tb_io_uart_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_pkg.sv
// Shared constants for the io_uart_tx register block: offsets, STATUS bit positions, FSM states.
package io_uart_pkg;

    // Register select values, taken from io_addr[3:2]
    localparam logic [1:0] TXDATA_OFF  = 2'd0;  // byte offset 0x0
    localparam logic [1:0] STATUS_OFF  = 2'd1;  // byte offset 0x4
    localparam logic [1:0] DIVISOR_OFF = 2'd2;  // byte offset 0x8

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_CNT_W   = 4;

    typedef logic [2:0] uart_tx_state_t;

    localparam uart_tx_state_t S_IDLE   = 3'd0;
    localparam uart_tx_state_t S_START  = 3'd1;
    localparam uart_tx_state_t S_DATA   = 3'd2;
    localparam uart_tx_state_t S_PARITY = 3'd3;
    localparam uart_tx_state_t S_STOP   = 3'd4;

    // A zero divisor would never finish a bit; run it as one clock per bit instead.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy counter; DEPTH must be a power of 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is judged before any same-cycle pop, so a pop never makes room for a simultaneous push.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter: TX FIFO fed by bus stores, serialised as 8N1 frames.
// Define IO_UART_PARITY_EN to insert an even-parity bit (8E1).
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0001_0000,
    parameter int          FIFO_DEPTH    = 8,
    parameter logic [15:0] CLK_DIV_RESET = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] io_addr,
    output logic [31:0] io_read_data,
    input  logic [31:0] io_write_data,
    input  logic        io_write_en,
    output logic        uart_tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic           sel;
    logic [1:0]     rsel;
    logic           wr_txdata;
    logic           wr_status;
    logic           wr_divisor;

    logic [15:0]    divisor;
    logic           overflow;

    logic           fifo_pop;
    logic [7:0]     fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;

    uart_tx_state_t state;
    logic [15:0]    div_lat;
    logic [15:0]    baud_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           bit_end;
`ifdef IO_UART_PARITY_EN
    logic           par_bit;
`endif

    logic unused_bits;
    assign unused_bits = &{1'b0, io_addr[1:0], io_write_data[31:16]};

    // ---------------- register decode ----------------
    assign sel        = (io_addr[31:4] == BASE_ADDR[31:4]);
    assign rsel       = io_addr[3:2];
    assign wr_txdata  = io_write_en && sel && (rsel == TXDATA_OFF);
    assign wr_status  = io_write_en && sel && (rsel == STATUS_OFF);
    assign wr_divisor = io_write_en && sel && (rsel == DIVISOR_OFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor  <= CLK_DIV_RESET;
            overflow <= 1'b0;
        end else begin
            if (wr_divisor) divisor <= io_write_data[15:0];
            if (wr_txdata && fifo_full)
                overflow <= 1'b1;
            else if (wr_status && io_write_data[STAT_OVF])
                overflow <= 1'b0;
        end
    end

    // Reads are side-effect free: the bus has no read strobe.
    always_comb begin
        io_read_data = '0;
        if (sel) begin
            case (rsel)
                STATUS_OFF: begin
                    io_read_data[STAT_FULL]  = fifo_full;
                    io_read_data[STAT_EMPTY] = fifo_empty;
                    io_read_data[STAT_BUSY]  = (state != S_IDLE);
                    io_read_data[STAT_OVF]   = overflow;
                    io_read_data[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
                end
                DIVISOR_OFF: io_read_data[15:0] = divisor;
                default:     io_read_data = '0;
            endcase
        end
    end

    // ---------------- TX FIFO ----------------
    assign fifo_pop = (state == S_IDLE) && !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_txdata),
        .wdata (io_write_data[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---------------- baud FSM ----------------
    assign bit_end = (baud_cnt == div_lat - 16'd1);

    // uart_tx is assigned alongside each transition so the line is a clean flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            uart_tx  <= 1'b1;
            div_lat  <= 16'd1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef IO_UART_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    uart_tx <= 1'b1;
                    if (!fifo_empty) begin
                        state    <= S_START;
                        shreg    <= fifo_head;
                        div_lat  <= eff_div(divisor);
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        uart_tx  <= 1'b0;
`ifdef IO_UART_PARITY_EN
                        par_bit  <= ^fifo_head;
`endif
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state    <= S_DATA;
                        baud_cnt <= '0;
                        uart_tx  <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef IO_UART_PARITY_EN
                            state   <= S_PARITY;
                            uart_tx <= par_bit;
`else
                            state   <= S_STOP;
                            uart_tx <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            uart_tx <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`ifdef IO_UART_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state    <= S_STOP;
                        baud_cnt <= '0;
                        uart_tx  <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    uart_tx <= 1'b1;
                    if (bit_end) begin
                        state    <= S_IDLE;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: register vector table, frame scoreboard, and corner sequences.
module tb_io_uart_tx;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_DV = BASE + 32'h8;
`ifdef IO_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] io_addr = '0;
    logic [31:0] io_write_data = '0;
    logic        io_write_en = 1'b0;
    logic [31:0] io_read_data;
    logic        uart_tx;

    io_uart_tx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .io_addr       (io_addr),
        .io_read_data  (io_read_data),
        .io_write_data (io_write_data),
        .io_write_en   (io_write_en),
        .uart_tx       (uart_tx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;
    frame_t sb[$];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        io_addr       = a;
        io_write_data = d;
        io_write_en   = 1'b1;
        @(posedge clk);
        #1 io_write_en = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        io_addr = a;
        #1 chk(name, io_read_data, exp);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] b;
        b[0]    = 1'b0;
        b[8:1]  = d;
`ifdef IO_UART_PARITY_EN
        b[9]    = ^d;
`else
        b[9]    = 1'b1;
`endif
        b[10]   = 1'b1;
        return b;
    endfunction

    // ---------------- line monitor ----------------
    // mon_pos: -1 waiting for start, -2 waiting for line high after an unexpected start.
    int          mon_pos = -1;
    int          mon_starts = 0;
    logic [10:0] mbits;
    int          mdiv;
    logic [7:0]  mdata;
    bit          mbad;
    int          mfirst;
    logic        mact;
    logic        mexp;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_pos = -1;
        end else begin
            if (mon_pos == -2 && uart_tx === 1'b1) begin
                mon_pos = -1;
            end else if (mon_pos == -1 && uart_tx === 1'b0) begin
                mon_starts++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got uart_tx=0 expected idle line (no byte queued)");
                    mon_pos = -2;
                end else begin
                    frame_t f;
                    f      = sb.pop_front();
                    mbits  = frame_bits(f.data);
                    mdiv   = f.div;
                    mdata  = f.data;
                    mbad   = 1'b0;
                    mon_pos = 0;
                end
            end
            if (mon_pos >= 0) begin
                // the sample after the last bit is the mandatory idle-high cycle
                mexp = (mon_pos / mdiv < NBITS) ? mbits[mon_pos / mdiv] : 1'b1;
                if (uart_tx !== mexp && !mbad) begin
                    mbad   = 1'b1;
                    mfirst = mon_pos;
                    mact   = uart_tx;
                end
                mon_pos++;
                if (mon_pos > NBITS * mdiv) begin
                    checks++;
                    if (mbad) begin
                        errors++;
                        $display("FAIL frame_%02h: sample %0d got %b expected %b (div %0d)",
                                 mdata, mfirst, mact, ~mact, mdiv);
                    end
                    mon_pos = -1;
                end
            end
        end
    end

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        io_addr = A_ST;
        do begin
            @(negedge clk);
            #1 n++;
        end while ((io_read_data[2] || !io_read_data[1] || mon_pos >= 0 || sb.size() != 0) && n < budget);
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s: got timeout after %0d cycles expected idle with empty scoreboard", name, n);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int starts_before;

        vt[0]  = '{1'b0, A_ST,            32'h0,         32'h2,    "rst_status"};
        vt[1]  = '{1'b0, A_DV,            32'h0,         32'd434,  "rst_divisor"};
        vt[2]  = '{1'b0, A_TX,            32'h0,         32'h0,    "txdata_read"};
        vt[3]  = '{1'b0, BASE + 32'hC,    32'h0,         32'h0,    "unmapped_read"};
        vt[4]  = '{1'b0, BASE + 32'h10,   32'h0,         32'h0,    "oob_read"};
        vt[5]  = '{1'b1, BASE + 32'h10,   32'hFFFF_FFFF, 32'h0,    ""};
        vt[6]  = '{1'b0, A_ST,            32'h0,         32'h2,    "oob_write_status"};
        vt[7]  = '{1'b0, A_DV,            32'h0,         32'd434,  "oob_write_div"};
        vt[8]  = '{1'b1, A_DV,            32'hABCD_1234, 32'h0,    ""};
        vt[9]  = '{1'b0, A_DV,            32'h0,         32'h1234, "div_upper_masked"};
        vt[10] = '{1'b1, BASE + 32'hC,    32'h0000_0007, 32'h0,    ""};
        vt[11] = '{1'b0, A_DV,            32'h0,         32'h1234, "unmapped_write"};
        vt[12] = '{1'b1, A_ST,            32'hFFFF_FFF7, 32'h0,    ""};
        vt[13] = '{1'b0, A_ST,            32'h0,         32'h2,    "status_ro_bits"};
        vt[14] = '{1'b1, A_DV,            32'h0000_0004, 32'h0,    ""};
        vt[15] = '{1'b0, A_DV,            32'h0,         32'h4,    "div_write"};

        repeat (3) @(negedge clk);
        chk("tx_in_reset", {31'b0, uart_tx}, 32'h1);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            if (vt[i].wr) wr_reg(vt[i].addr, vt[i].data);
            else          rd_chk(vt[i].addr, vt[i].exp, vt[i].name);
        end

        // 0xA5 at divisor 4: push visible after edge N, pop and start bit after N+1
        sb.push_back('{8'hA5, 4});
        wr_reg(A_TX, 32'hA5);
        rd_chk(A_ST, 32'h0000_0100, "push_status");
        chk("tx_before_pop", {31'b0, uart_tx}, 32'h1);
        rd_chk(A_ST, 32'h0000_0006, "pop_status");
        chk("tx_start_bit", {31'b0, uart_tx}, 32'h0);
        wait_idle(200, "wait_a5");

        // back-to-back fill at divisor 2, overflow on the tenth write
        wr_reg(A_DV, 32'd2);
        for (int i = 0; i < 9; i++) begin
            sb.push_back('{8'(i), 2});
            wr_reg(A_TX, 32'(i));
        end
        rd_chk(A_ST, 32'h0000_0805, "fifo_full");
        wr_reg(A_TX, 32'h09);
        rd_chk(A_ST, 32'h0000_080D, "overflow_set");
        wr_reg(A_ST, 32'h8);
        rd_chk(A_ST, 32'h0000_0805, "overflow_clear");
        wait_idle(1000, "wait_fill");
        rd_chk(A_ST, 32'h0000_0002, "drained_status");

        // divisor change mid-frame applies to the next frame only
        wr_reg(A_DV, 32'd4);
        sb.push_back('{8'h5A, 4});
        wr_reg(A_TX, 32'h5A);
        repeat (6) @(negedge clk);
        wr_reg(A_DV, 32'd8);
        sb.push_back('{8'hC3, 8});
        wr_reg(A_TX, 32'hC3);
        rd_chk(A_DV, 32'd8, "div_midframe_read");
        wait_idle(600, "wait_divchg");

        // divisor 0 runs at one clock per bit
        wr_reg(A_DV, 32'd0);
        sb.push_back('{8'h81, 1});
        wr_reg(A_TX, 32'h81);
        wait_idle(200, "wait_div0");

        // reset in the middle of DATA with two bytes queued
        wr_reg(A_DV, 32'd4);
        sb.push_back('{8'h3C, 4});
        wr_reg(A_TX, 32'h3C);
        wr_reg(A_TX, 32'h11);
        wr_reg(A_TX, 32'h22);
        repeat (7) @(negedge clk);
        chk("tx_low_before_reset", {31'b0, uart_tx}, 32'h0);
        #2 rst_n = 1'b0;
        #1 chk("tx_async_reset", {31'b0, uart_tx}, 32'h1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        starts_before = mon_starts;
        rd_chk(A_ST, 32'h0000_0002, "status_after_reset");
        rd_chk(A_DV, 32'd434, "div_after_reset");
        repeat (300) @(negedge clk);
        chk("no_frames_after_reset", 32'(mon_starts), 32'(starts_before));
        chk("line_idle_after_reset", {31'b0, uart_tx}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
